ct_ifu_icache_refill_wr: RTL and testbench

- Refill write sequencer that sits directly upstream of icache data array 1 and drives its bank enables, clock enables, write enable, data and index.
- Accepts a refill request (line address), then BEATS x 128-bit refill beats through a valid/ready handshake, buffering them in a small FIFO.
- Writes one 128-bit row per cycle into all four 32-bit banks, yielding to fetch reads.
- Pulses done after the last row is written so the tag/valid update stage can set the line valid.

---
 rtl/ct_ifu_icache_pkg.sv | 31 +++
 rtl/ct_ifu_refill_beat_fifo.sv | 62 ++++++
 rtl/ct_ifu_icache_refill_wr.sv | 159 +++++++++++++++
 tb/tb_ct_ifu_icache_refill_wr.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_ifu_icache_pkg.sv
//------------------------------------------------------------------------------
// ct_ifu_icache_pkg : shared constants for the icache refill write path
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ct_ifu_icache_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_FILL = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int LINE_BYTES = 64;
    localparam int BANK_W     = 32;
    localparam int NUM_BANKS  = 4;
    localparam int ROW_W      = BANK_W * NUM_BANKS;

    // Data-array address MSB for each supported cache size
    localparam int WIDTH_32K  = 12;
    localparam int WIDTH_64K  = 13;
    localparam int WIDTH_128K = 14;
    localparam int WIDTH_256K = 15;

    function automatic bit width_is_legal(input int w);
        return (w == WIDTH_32K) || (w == WIDTH_64K) ||
               (w == WIDTH_128K) || (w == WIDTH_256K);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ct_ifu_refill_beat_fifo.sv
//------------------------------------------------------------------------------
// ct_ifu_refill_beat_fifo : small refill beat buffer with flush and push+pop on full
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ct_ifu_refill_beat_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_full    = (r_count == C_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    // A push into a full buffer is legal only when the head leaves in the same cycle
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

`default_nettype wire

// File: rtl/ct_ifu_icache_refill_wr.sv
//------------------------------------------------------------------------------
// ct_ifu_icache_refill_wr : buffers refill beats and writes them row by row
// into icache data array 1, yielding to fetch reads.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ct_ifu_icache_refill_wr
    import ct_ifu_icache_pkg::*;
#(
    parameter int WIDTH      = WIDTH_32K,
    parameter int BEATS      = LINE_BYTES * 8 / ROW_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             refill_req_vld,
    input  logic [15:6]      refill_req_addr,
    output logic             refill_req_rdy,
    input  logic             refill_beat_vld,
    input  logic [ROW_W-1:0] refill_beat_data,
    output logic             refill_beat_rdy,
    input  logic             refill_abort,
    input  logic             ifu_fetch_rd_req,
    output logic             refill_done,
    output logic             ifu_icache_data_array1_bank0_cen_b,
    output logic             ifu_icache_data_array1_bank1_cen_b,
    output logic             ifu_icache_data_array1_bank2_cen_b,
    output logic             ifu_icache_data_array1_bank3_cen_b,
    output logic             ifu_icache_data_array1_bank0_clk_en,
    output logic             ifu_icache_data_array1_bank1_clk_en,
    output logic             ifu_icache_data_array1_bank2_clk_en,
    output logic             ifu_icache_data_array1_bank3_clk_en,
    output logic             ifu_icache_data_array1_wen_b,
    output logic [ROW_W-1:0] ifu_icache_data_array1_din,
    output logic [15:0]      ifu_icache_index,
    output logic             refill_busy
);

    localparam int CW = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] C_BEATS = CW'(BEATS);

    // The index carries a fixed two-bit row field, so only a 4-beat line fits
    generate
        if (!width_is_legal(WIDTH) || BEATS != 4 || FIFO_DEPTH < 2) begin : g_bad_cfg
            $error("ct_ifu_icache_refill_wr: unsupported parameter set");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [15:6]      r_addr;
    logic [CW-1:0]    r_rx_cnt;
    logic [CW-1:0]    r_wr_cnt;
    logic             r_wr_en;
    logic             r_done;
    logic [ROW_W-1:0] r_din;
    logic [15:0]      r_index;

    logic             w_fill;
    logic             w_pop;
    logic             w_push;
    logic             w_beat_rdy;
    logic             w_last_wr;
    logic             w_flush;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [ROW_W-1:0] w_fifo_head;

    assign w_fill     = (r_state == ST_FILL);
    assign w_pop      = w_fill & ~w_fifo_empty & ~ifu_fetch_rd_req & ~refill_abort;
    assign w_beat_rdy = w_fill & ~refill_abort & (r_rx_cnt < C_BEATS) &
                        (~w_fifo_full | w_pop);
    assign w_push     = refill_beat_vld & w_beat_rdy;
    assign w_flush    = w_fill & refill_abort;
    assign w_last_wr  = w_pop & (r_wr_cnt == C_BEATS - 1'b1);

    ct_ifu_refill_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ROW_W)
    ) u_beat_fifo (
        .clk     (forever_cpuclk),
        .rst     (cpurst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (refill_beat_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_rx_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (refill_req_vld) begin
                        r_state  <= ST_FILL;
                        r_addr   <= refill_req_addr;
                        r_rx_cnt <= '0;
                        r_wr_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    if (refill_abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if (w_push) r_rx_cnt <= r_rx_cnt + 1'b1;
                        if (w_pop && r_wr_cnt != C_BEATS) r_wr_cnt <= r_wr_cnt + 1'b1;
                        if (w_last_wr) r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Array-facing outputs are registered: the pop decision drives the array next cycle
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_din   <= '0;
            r_index <= '0;
        end else begin
            r_wr_en <= w_pop;
            r_done  <= (r_state == ST_DONE);
            if (w_pop) begin
                r_din   <= w_fifo_head;
                r_index <= {r_addr, r_wr_cnt[1:0], 4'b0000};
            end
        end
    end

    assign refill_req_rdy  = (r_state == ST_IDLE);
    assign refill_busy     = (r_state != ST_IDLE);
    assign refill_beat_rdy = w_beat_rdy;
    assign refill_done     = r_done;

    assign ifu_icache_data_array1_bank0_cen_b  = ~r_wr_en;
    assign ifu_icache_data_array1_bank1_cen_b  = ~r_wr_en;
    assign ifu_icache_data_array1_bank2_cen_b  = ~r_wr_en;
    assign ifu_icache_data_array1_bank3_cen_b  = ~r_wr_en;
    assign ifu_icache_data_array1_bank0_clk_en = r_wr_en;
    assign ifu_icache_data_array1_bank1_clk_en = r_wr_en;
    assign ifu_icache_data_array1_bank2_clk_en = r_wr_en;
    assign ifu_icache_data_array1_bank3_clk_en = r_wr_en;
    assign ifu_icache_data_array1_wen_b        = ~r_wr_en;
    assign ifu_icache_data_array1_din          = r_din;
    assign ifu_icache_index                    = r_index;

endmodule

`default_nettype wire

// File: tb/tb_ct_ifu_icache_refill_wr.sv
//------------------------------------------------------------------------------
// tb_ct_ifu_icache_refill_wr : directed self-checking bench for the refill writer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ct_ifu_icache_refill_wr;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_vld;
    logic [15:6]  req_addr;
    logic         req_rdy;
    logic         beat_vld;
    logic [127:0] beat_data;
    logic         beat_rdy;
    logic         abort;
    logic         rd_req;
    logic         done;
    logic         cen0, cen1, cen2, cen3;
    logic         cke0, cke1, cke2, cke3;
    logic         wen_b;
    logic [127:0] din;
    logic [15:0]  index;
    logic         busy;

    ct_ifu_icache_refill_wr dut (
        .forever_cpuclk                      (clk),
        .cpurst                              (rst),
        .refill_req_vld                      (req_vld),
        .refill_req_addr                     (req_addr),
        .refill_req_rdy                      (req_rdy),
        .refill_beat_vld                     (beat_vld),
        .refill_beat_data                    (beat_data),
        .refill_beat_rdy                     (beat_rdy),
        .refill_abort                        (abort),
        .ifu_fetch_rd_req                    (rd_req),
        .refill_done                         (done),
        .ifu_icache_data_array1_bank0_cen_b  (cen0),
        .ifu_icache_data_array1_bank1_cen_b  (cen1),
        .ifu_icache_data_array1_bank2_cen_b  (cen2),
        .ifu_icache_data_array1_bank3_cen_b  (cen3),
        .ifu_icache_data_array1_bank0_clk_en (cke0),
        .ifu_icache_data_array1_bank1_clk_en (cke1),
        .ifu_icache_data_array1_bank2_clk_en (cke2),
        .ifu_icache_data_array1_bank3_clk_en (cke3),
        .ifu_icache_data_array1_wen_b        (wen_b),
        .ifu_icache_data_array1_din          (din),
        .ifu_icache_index                    (index),
        .refill_busy                         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    logic [127:0] D [0:3];
    logic [127:0] D5;

    int           wr_cyc [$];
    logic [15:0]  wr_idx [$];
    logic [127:0] wr_dat [$];
    int           done_cyc [$];

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Array-port monitor: logs every row write and done pulse, checks strobe coherence
    always @(negedge clk) begin
        if (started) begin
            check("strobes", {cen0, cen1, cen2, cen3, cke0, cke1, cke2, cke3},
                  wen_b ? 128'hF0 : 128'h0F);
            if (!wen_b) begin
                wr_cyc.push_back(cyc);
                wr_idx.push_back(index);
                wr_dat.push_back(din);
            end
            if (done) done_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        wr_cyc.delete();
        wr_idx.delete();
        wr_dat.delete();
        done_cyc.delete();
    endtask

    task automatic send_req(input logic [15:6] a);
        req_vld  = 1'b1;
        req_addr = a;
        @(negedge clk);
        check("req_rdy_idle", req_rdy, 1);
        tick(1);
        req_vld = 1'b0;
    endtask

    // Returns the cycle in which the beat handshake completed
    task automatic send_beat(input logic [127:0] d, output int acc);
        int n;
        n         = 0;
        acc       = -1;
        beat_vld  = 1'b1;
        beat_data = d;
        while (acc < 0) begin
            @(negedge clk);
            if (beat_rdy) acc = cyc;
            else begin
                n++;
                if (n > 50) begin
                    check("beat_timeout", 1, 0);
                    break;
                end
            end
        end
        tick(1);
        beat_vld = 1'b0;
    endtask

    // Expects exactly one full line: four consecutive writes starting at first, done one cycle after
    task automatic check_line(input string tag, input logic [15:0] base, input int first);
        check({tag, "_nwr"}, wr_cyc.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < wr_cyc.size()) begin
                check({tag, "_idx"}, wr_idx[k], base + 16'(16 * k));
                check({tag, "_dat"}, wr_dat[k], D[k]);
                check({tag, "_cyc"}, wr_cyc[k], first + k);
            end
        end
        check({tag, "_ndone"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) check({tag, "_done_cyc"}, done_cyc[0], first + 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3, c0, nwr;

        D[0] = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAA0;
        D[1] = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBB1;
        D[2] = 128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCC2;
        D[3] = 128'hDDDDDDDD_DDDDDDDD_DDDDDDDD_DDDDDDD3;
        D5   = 128'h55555555_55555555_55555555_55555555;

        rst = 1'b1; req_vld = 1'b0; req_addr = '0; beat_vld = 1'b0;
        beat_data = '0; abort = 1'b0; rd_req = 1'b0;
        tick(3);
        rst = 1'b0;
        started = 1'b1;
        @(negedge clk);
        check("rst_ctrl", {req_rdy, beat_rdy, done, busy, wen_b}, 5'b10001);
        check("rst_din", din, 0);
        check("rst_index", index, 0);
        tick(1);

        // Basic refill plus an extra beat that must be refused
        clear_logs();
        send_req(10'h155);
        check("t1_busy_rdy", {busy, req_rdy}, 2'b10);
        send_beat(D[0], a0);
        send_beat(D[1], a1);
        send_beat(D[2], a2);
        send_beat(D[3], a3);
        check("t1_b2b_accept", a3, a0 + 3);
        beat_vld  = 1'b1;
        beat_data = D5;
        @(negedge clk);
        check("t6_extra_rdy0", beat_rdy, 0);
        tick(1);
        @(negedge clk);
        check("t6_extra_rdy0b", beat_rdy, 0);
        tick(1);
        beat_vld = 1'b0;
        tick(4);
        check_line("t1", 16'h5540, a0 + 2);

        // Read conflict for five cycles; third beat lands on a full FIFO while it pops
        clear_logs();
        send_req(10'h2F1);
        c0 = cyc;
        rd_req = 1'b1;
        fork
            begin
                tick(5);
                rd_req = 1'b0;
            end
        join_none
        send_beat(D[0], a0);
        send_beat(D[1], a1);
        send_beat(D[2], a2);
        send_beat(D[3], a3);
        tick(6);
        check("t2_acc0", a0, c0);
        check("t2_acc1", a1, c0 + 1);
        check("t2_fullpush", a2, c0 + 5);
        check("t2_acc3", a3, c0 + 6);
        check_line("t2", 16'hBC40, c0 + 6);

        // Abort after two rows, then a clean refill
        clear_logs();
        send_req(10'h0AA);
        send_beat(D[0], a0);
        send_beat(D[1], a1);
        send_beat(D[2], a2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        @(negedge clk);
        check("t3_req_rdy", {req_rdy, busy}, 2'b10);
        tick(5);
        check("t3_nwr", wr_cyc.size(), 2);
        if (wr_cyc.size() == 2) begin
            check("t3_idx1", wr_idx[1], 16'h2A90);
            check("t3_dat1", wr_dat[1], D[1]);
        end
        check("t3_nodone", done_cyc.size(), 0);
        clear_logs();
        send_req(10'h3C0);
        send_beat(D[0], a0);
        send_beat(D[1], a1);
        send_beat(D[2], a2);
        send_beat(D[3], a3);
        tick(5);
        check_line("t3b", 16'hF000, a0 + 2);

        // Synchronous reset in the middle of a fill
        clear_logs();
        send_req(10'h001);
        send_beat(D[0], a0);
        send_beat(D[1], a1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ctrl", {req_rdy, beat_rdy, done, busy, wen_b}, 5'b10001);
        check("t5_strobes", {cen0, cen1, cen2, cen3, cke0, cke1, cke2, cke3}, 128'hF0);
        check("t5_din", din, 0);
        nwr = wr_cyc.size();
        tick(6);
        check("t5_nowr", wr_cyc.size(), nwr);
        check("t5_nodone", done_cyc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
